// File: rtl/alu_seq.sv
// alu_seq: registered execute-stage ALU with single-cycle ops and iterative MUL/MULH/DIV/REM
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_req, i_kill     start request (taken only when idle), abort/flush
//   i_mode            op select: 0 PASS_L 1 PASS_R 2 ADD 3 SUB 4 AND 5 OR 6 XOR 7 SHL 8 SHR
//                     9 ASHR 10 SEXT 11 MUL 12 MULH 13 DIV 14 REM 15 PASS_L
//   i_l, i_r, i_carry operands and carry/borrow in
//   o_busy            multi-cycle op in flight
//   o_valid           one-cycle pulse when o_out/o_flags update
//   o_out, o_flags    result and {P,O,N,C,Z}, held until the next o_valid
// Build option: define ALU_MUL_EARLY_TERM_EN to let MUL/MULH stop once the multiplier is exhausted.
module alu_seq #(
    parameter int RW     = 16,
    parameter int MODE_W = 4,
    parameter int CNT_W  = $clog2(RW + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_kill,
    input  logic [MODE_W-1:0] i_mode,
    input  logic [RW-1:0]     i_l,
    input  logic [RW-1:0]     i_r,
    input  logic              i_carry,
    output logic              o_busy,
    output logic              o_valid,
    output logic [RW-1:0]     o_out,
    output logic [4:0]        o_flags
);
    localparam logic [MODE_W-1:0] M_PASSR = MODE_W'(1);
    localparam logic [MODE_W-1:0] M_ADD   = MODE_W'(2);
    localparam logic [MODE_W-1:0] M_SUB   = MODE_W'(3);
    localparam logic [MODE_W-1:0] M_AND   = MODE_W'(4);
    localparam logic [MODE_W-1:0] M_OR    = MODE_W'(5);
    localparam logic [MODE_W-1:0] M_XOR   = MODE_W'(6);
    localparam logic [MODE_W-1:0] M_SHL   = MODE_W'(7);
    localparam logic [MODE_W-1:0] M_SHR   = MODE_W'(8);
    localparam logic [MODE_W-1:0] M_ASHR  = MODE_W'(9);
    localparam logic [MODE_W-1:0] M_SEXT  = MODE_W'(10);
    localparam logic [MODE_W-1:0] M_MUL   = MODE_W'(11);
    localparam logic [MODE_W-1:0] M_MULH  = MODE_W'(12);
    localparam logic [MODE_W-1:0] M_DIV   = MODE_W'(13);
    localparam logic [MODE_W-1:0] M_REM   = MODE_W'(14);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RW-1:0]     out_q, out_d;
    logic [4:0]        flags_q, flags_d;
    logic              valid_q, valid_d;
    logic              hi_q, hi_d;
    logic [2*RW-1:0]   acc_q, acc_d, mcd_q, mcd_d, acc_n;
    logic [RW-1:0]     mpl_q, mpl_d, mpl_n;
    logic [RW-1:0]     rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, rem_n, quo_n;
    logic [RW:0]       partial;
    logic              ge;
    logic              mul_done;
    logic [RW-1:0]     mres, dres;
    logic [RW:0]       add_w, sub_w, shl_w, shr_w, asr_w;
    logic [RW-1:0]     sext, res;
    logic              c, o, amt_big;

    function automatic logic [4:0] mk_flags(input logic [RW-1:0] v, input logic cf, input logic of);
        return {^v, of, v[RW-1], cf, v == '0};
    endfunction

    generate
        if (RW > 8) begin : g_sext
            assign sext = {{(RW-8){i_l[7]}}, i_l[7:0]};
        end else begin : g_nosext
            assign sext = i_l;
        end
    endgenerate

    // Shifts run on an RW+1 wide copy so the last bit shifted out lands in the spare bit.
    always_comb begin
        add_w   = {1'b0, i_l} + {1'b0, i_r} + {{RW{1'b0}}, i_carry};
        sub_w   = {1'b0, i_l} - {1'b0, i_r} - {{RW{1'b0}}, i_carry};
        shl_w   = {1'b0, i_l} << i_r;
        shr_w   = {i_l, 1'b0} >> i_r;
        asr_w   = $signed({i_l, 1'b0}) >>> i_r;
        amt_big = i_r >= RW'(RW);
        res     = i_l;
        c       = 1'b0;
        o       = 1'b0;
        case (i_mode)
            M_PASSR: res = i_r;
            M_ADD: begin
                res = add_w[RW-1:0];
                c   = add_w[RW];
                o   = ~(i_l[RW-1] ^ i_r[RW-1]) & (i_l[RW-1] ^ add_w[RW-1]);
            end
            M_SUB: begin
                res = sub_w[RW-1:0];
                c   = sub_w[RW];
                o   = (i_l[RW-1] ^ i_r[RW-1]) & (i_l[RW-1] ^ sub_w[RW-1]);
            end
            M_AND:  res = i_l & i_r;
            M_OR:   res = i_l | i_r;
            M_XOR:  res = i_l ^ i_r;
            M_SHL: begin
                res = shl_w[RW-1:0];
                c   = shl_w[RW] & ~amt_big;
            end
            M_SHR: begin
                res = shr_w[RW:1];
                c   = shr_w[0] & ~amt_big;
            end
            M_ASHR: begin
                res = asr_w[RW:1];
                c   = asr_w[0] & ~amt_big;
            end
            M_SEXT: res = sext;
            default: ;
        endcase
    end

    // One shift-add step and one restoring-divide step per edge.
    always_comb begin
        acc_n   = mpl_q[0] ? acc_q + mcd_q : acc_q;
        mpl_n   = mpl_q >> 1;
        partial = {rem_q, quo_q[RW-1]};
        ge      = partial >= {1'b0, dvs_q};
        rem_n   = ge ? RW'(partial - {1'b0, dvs_q}) : partial[RW-1:0];
        quo_n   = {quo_q[RW-2:0], ge};
        mres    = hi_q ? acc_n[2*RW-1:RW] : acc_n[RW-1:0];
        dres    = hi_q ? rem_n : quo_n;
    end

`ifdef ALU_MUL_EARLY_TERM_EN
    assign mul_done = (cnt_q == CNT_W'(1)) || (mpl_n == '0);
`else
    assign mul_done = cnt_q == CNT_W'(1);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        flags_d = flags_q;
        valid_d = 1'b0;
        hi_d    = hi_q;
        acc_d   = acc_q;
        mcd_d   = mcd_q;
        mpl_d   = mpl_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        case (state_q)
            S_IDLE: begin
                if (i_req && !i_kill) begin
                    if (i_mode == M_MUL || i_mode == M_MULH) begin
                        state_d = S_MUL;
                        cnt_d   = CNT_W'(RW);
                        hi_d    = i_mode == M_MULH;
                        acc_d   = '0;
                        mcd_d   = {{RW{1'b0}}, i_l};
                        mpl_d   = i_r;
                    end else if (i_mode == M_DIV || i_mode == M_REM) begin
                        state_d = S_DIV;
                        cnt_d   = CNT_W'(RW);
                        hi_d    = i_mode == M_REM;
                        rem_d   = '0;
                        quo_d   = i_l;
                        dvs_d   = i_r;
                    end else begin
                        out_d   = res;
                        flags_d = mk_flags(res, c, o);
                        valid_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (i_kill) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = acc_n;
                    mcd_d = mcd_q << 1;
                    mpl_d = mpl_n;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (mul_done) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        out_d   = mres;
                        flags_d = mk_flags(mres, |acc_n[2*RW-1:RW], |acc_n[2*RW-1:RW]);
                        valid_d = 1'b1;
                    end
                end
            end
            S_DIV: begin
                if (i_kill) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    rem_d = rem_n;
                    quo_d = quo_n;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        // A zero divisor naturally yields all-ones quotient and remainder = dividend.
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        out_d   = dres;
                        flags_d = mk_flags(dres, 1'b0, dvs_q == '0);
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
            hi_q    <= 1'b0;
            acc_q   <= '0;
            mcd_q   <= '0;
            mpl_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
            hi_q    <= hi_d;
            acc_q   <= acc_d;
            mcd_q   <= mcd_d;
            mpl_q   <= mpl_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
        end
    end

    assign o_busy  = state_q != S_IDLE;
    assign o_valid = valid_q;
    assign o_out   = out_q;
    assign o_flags = flags_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
    localparam int     RW = 16;
    localparam longint M  = longint'(1) << RW;

    logic          i_clk = 1'b0;
    logic          i_rst, i_req, i_kill, i_carry;
    logic [3:0]    i_mode;
    logic [RW-1:0] i_l, i_r;
    logic          o_busy, o_valid;
    logic [RW-1:0] o_out;
    logic [4:0]    o_flags;

    int passed = 0;
    int fails  = 0;
    int total  = 0;
    logic [RW-1:0] last_out;
    logic [4:0]    last_flags;

    alu_seq #(.RW(RW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_kill(i_kill), .i_mode(i_mode),
        .i_l(i_l), .i_r(i_r), .i_carry(i_carry), .o_busy(o_busy), .o_valid(o_valid),
        .o_out(o_out), .o_flags(o_flags)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Result and {P,O,N,C,Z} computed with plain integer arithmetic.
    function automatic logic [RW+4:0] model(input int mode, input logic [RW-1:0] lv, input logic [RW-1:0] rv, input logic cin);
        longint l, r, sl, sr, res, p, s;
        logic cf, of;
        logic [RW-1:0] v;
        l  = longint'(lv);
        r  = longint'(rv);
        sl = (l >= M / 2) ? l - M : l;
        sr = (r >= M / 2) ? r - M : r;
        p  = l * r;
        cf = 1'b0;
        of = 1'b0;
        res = l;
        case (mode)
            1: res = r;
            2: begin
                res = l + r + longint'(cin);
                cf  = res >= M;
                s   = sl + sr + longint'(cin);
                of  = (s >= M / 2) || (s < -M / 2);
            end
            3: begin
                res = l - r - longint'(cin);
                cf  = res < 0;
                s   = sl - sr - longint'(cin);
                of  = (s >= M / 2) || (s < -M / 2);
            end
            4: res = l & r;
            5: res = l | r;
            6: res = l ^ r;
            7: if (r < RW) begin
                res = l << r;
                cf  = (r > 0) && (((l >> (RW - r)) & 1) == 1);
            end else res = 0;
            8: if (r < RW) begin
                res = l >> r;
                cf  = (r > 0) && (((l >> (r - 1)) & 1) == 1);
            end else res = 0;
            9: if (r < RW) begin
                res = sl >>> r;
                cf  = (r > 0) && (((l >> (r - 1)) & 1) == 1);
            end else res = (sl < 0) ? -1 : 0;
            10: res = ((l & 255) >= 128) ? (l & 255) - 256 : (l & 255);
            11: begin res = p % M; cf = p >= M; of = p >= M; end
            12: begin res = p / M; cf = p >= M; of = p >= M; end
            13: if (r == 0) begin res = M - 1; of = 1'b1; end else res = l / r;
            14: if (r == 0) begin res = l; of = 1'b1; end else res = l % r;
            default: res = l;
        endcase
        res = res & (M - 1);
        v = res[RW-1:0];
        return {^v, of, v[RW-1], cf, v == '0, v};
    endfunction

    // Cycles from the accepting edge to the edge that raises o_valid.
    function automatic int exp_lat(input int mode, input logic [RW-1:0] rv);
        int hb;
        hb = 0;
        if (mode == 13 || mode == 14) return RW;
        if (mode != 11 && mode != 12) return 0;
`ifdef ALU_MUL_EARLY_TERM_EN
        for (int i = 0; i < RW; i++) if (rv[i]) hb = i + 1;
        return (hb < 1) ? 1 : hb;
`else
        return RW;
`endif
    endfunction

    task automatic run_op(input logic [3:0] mode, input logic [RW-1:0] l, input logic [RW-1:0] r, input logic cin, input string tag);
        logic [RW+4:0] e;
        int lat, n;
        e   = model(int'(mode), l, r, cin);
        lat = exp_lat(int'(mode), r);
        i_req = 1'b1; i_mode = mode; i_l = l; i_r = r; i_carry = cin;
        tick;
        i_req = 1'b0; i_mode = 4'($urandom); i_l = RW'($urandom); i_r = RW'($urandom); i_carry = 1'($urandom);
        n = 0;
        if (lat > 0) check({tag, "_busy"}, 32'(o_busy), 32'(1));
        while (!o_valid && n < 3 * RW) begin
            tick;
            n++;
        end
        check({tag, "_lat"}, n, lat);
        check({tag, "_out"}, 32'(o_out), 32'(e[RW-1:0]));
        check({tag, "_flags"}, 32'(o_flags), 32'(e[RW+4:RW]));
        last_out   = e[RW-1:0];
        last_flags = e[RW+4:RW];
    endtask

    initial begin
        logic [RW+4:0] e;
        int nv;
        logic [3:0] md;
        logic [RW-1:0] rr;
        i_rst = 1'b1; i_req = 1'b0; i_kill = 1'b0; i_mode = 4'd0; i_l = '0; i_r = '0; i_carry = 1'b0;
        tick;
        tick;
        check("rst_busy", 32'(o_busy), 0);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_out", 32'(o_out), 0);
        check("rst_flags", 32'(o_flags), 0);
        i_rst = 1'b0;
        tick;

        run_op(4'd2, 16'h7fff, 16'h0001, 1'b0, "add_ovf");
        run_op(4'd3, 16'h0000, 16'h0001, 1'b0, "sub_borrow");
        run_op(4'd9, 16'h8000, 16'd20, 1'b0, "ashr_big");
        run_op(4'd8, 16'h8001, 16'd0, 1'b0, "shr_zero");
        run_op(4'd7, 16'hc001, 16'd1, 1'b0, "shl_one");
        run_op(4'd11, 16'h1234, 16'h0100, 1'b0, "mul");
        run_op(4'd12, 16'h1234, 16'h0100, 1'b0, "mulh");
        run_op(4'd13, 16'd100, 16'd7, 1'b0, "div");
        run_op(4'd14, 16'd100, 16'd7, 1'b0, "rem");
        run_op(4'd13, 16'h1234, 16'h0000, 1'b0, "div0");
        run_op(4'd14, 16'h1234, 16'h0000, 1'b0, "rem0");
        tick;
        check("valid_pulse", 32'(o_valid), 0);

        // Kill a divide in flight.
        i_req = 1'b1; i_mode = 4'd13; i_l = 16'd1000; i_r = 16'd3;
        tick;
        i_req = 1'b0;
        repeat (4) tick;
        i_kill = 1'b1;
        tick;
        i_kill = 1'b0;
        check("kill_busy", 32'(o_busy), 0);
        check("kill_valid", 32'(o_valid), 0);
        check("kill_out", 32'(o_out), 32'(last_out));
        check("kill_flags", 32'(o_flags), 32'(last_flags));
        nv = 0;
        repeat (RW + 2) begin
            tick;
            if (o_valid) nv++;
        end
        check("kill_novalid", nv, 0);

        // Kill together with a request in idle drops it.
        i_req = 1'b1; i_kill = 1'b1; i_mode = 4'd2; i_l = 16'd5; i_r = 16'd6;
        tick;
        i_req = 1'b0; i_kill = 1'b0;
        check("kreq_valid", 32'(o_valid), 0);
        check("kreq_busy", 32'(o_busy), 0);
        check("kreq_out", 32'(o_out), 32'(last_out));

        // A request while busy is ignored.
        e = model(11, 16'h00ff, 16'h0f0f, 1'b0);
        i_req = 1'b1; i_mode = 4'd11; i_l = 16'h00ff; i_r = 16'h0f0f;
        tick;
        i_req = 1'b0;
        tick;
        i_req = 1'b1; i_mode = 4'd2; i_l = 16'd1; i_r = 16'd1;
        tick;
        i_req = 1'b0;
        nv = 0;
        repeat (RW + 4) begin
            tick;
            if (o_valid) begin
                nv++;
                check("ign_out", 32'(o_out), 32'(e[RW-1:0]));
                check("ign_flags", 32'(o_flags), 32'(e[RW+4:RW]));
            end
        end
        check("ign_count", nv, 1);

        // Asynchronous reset in the middle of a multiply.
        i_req = 1'b1; i_mode = 4'd11; i_l = 16'h1234; i_r = 16'hffff;
        tick;
        i_req = 1'b0;
        repeat (7) tick;
        #2 i_rst = 1'b1;
        #1;
        check("arst_busy", 32'(o_busy), 0);
        check("arst_valid", 32'(o_valid), 0);
        check("arst_out", 32'(o_out), 0);
        check("arst_flags", 32'(o_flags), 0);
        tick;
        i_rst = 1'b0;
        nv = 0;
        repeat (RW + 2) begin
            tick;
            if (o_valid) nv++;
        end
        check("arst_novalid", nv, 0);

        // Random back-to-back traffic across all modes.
        for (int k = 0; k < 150; k++) begin
            md = 4'($urandom_range(0, 15));
            rr = RW'($urandom);
            if (md >= 4'd7 && md <= 4'd9) rr = RW'($urandom_range(0, RW + 3));
            if ((md == 4'd13 || md == 4'd14) && $urandom_range(0, 7) == 0) rr = '0;
            if ((md == 4'd11 || md == 4'd12) && $urandom_range(0, 3) == 0) rr = RW'($urandom_range(0, 255));
            run_op(md, RW'($urandom), rr, 1'($urandom), $sformatf("rnd%0d_m%0d", k, md));
        end
        tick;
        check("end_valid", 32'(o_valid), 0);
        check("end_busy", 32'(o_busy), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
